// File: rtl/pipe_stage_buf.sv
// Elastic in-order pipeline-stage buffer carrying {inst, pc} beats with valid/ready, flush-to-bubble.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        PC_W     = 32,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'hF000_0000)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INST_W-1:0]            in_inst,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INST_W-1:0]            out_inst,
  output logic [PC_W-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   out_level
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
`endif
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } beat_t;

  beat_t          mem_q [DEPTH];
  beat_t          mem_d [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           push_c, pop_c;

  // Explicit wrap so non-power-of-two depths index only valid entries
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Handshake and head presentation; flush forces both sides idle
  always_comb begin
    in_ready  = !flush && ((level_q < LVL_FULL) || out_ready);
    out_valid = !flush && (level_q != '0);
    push_c    = in_valid && in_ready;
    pop_c     = out_valid && out_ready;
    out_inst  = NOP_INST;
    out_pc    = '0;
    out_level = level_q;
    if (out_valid) begin
      out_inst = mem_q[rd_ptr_q].inst;
      out_pc   = mem_q[rd_ptr_q].pc;
    end
  end

  // Next-state for pointers, occupancy and storage
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) begin
        mem_d[wr_ptr_q].inst = in_inst;
        mem_d[wr_ptr_q].pc   = in_pc;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_c, pop_c})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [32:0] flush_sum_c;

  // Saturating counters: stalled head cycles and beats discarded by flush
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    flush_sum_c = 33'(flush_cnt_q) + 33'(level_q);
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush) begin
      flush_cnt_d = flush_sum_c[32] ? 32'hFFFF_FFFF : flush_sum_c[31:0];
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
`ifdef PIPE_STAGE_PERF_EN
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
`endif
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
`ifdef PIPE_STAGE_PERF_EN
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end

  // Storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: DEPTH=2 directed steps plus DEPTH=1/3 random-backpressure runs.
module tb_pipe_stage_buf;

  localparam int N = 3;
  localparam logic [31:0] NOP = 32'hF000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [N-1:0]          flush, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0][31:0]    in_inst, in_pc, out_inst, out_pc;
  logic [N-1:0][3:0]     out_level;
`ifdef PIPE_STAGE_PERF_EN
  logic [N-1:0][31:0]    stall_cnt, flush_cnt;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] sb [N][$];
  int          n_out [N];
  longint      exp_stall [N];
  longint      exp_flush [N];
  int          idx [N];

  function automatic int depth_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    logic [$clog2(D+1)-1:0] lvl;
    pipe_stage_buf #(
      .INST_W(32), .PC_W(32), .DEPTH(D), .NOP_INST(32'hF000_0000)
    ) u_dut (
      .clk(clk), .reset(reset), .flush(flush[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_inst(in_inst[g]), .in_pc(in_pc[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_inst(out_inst[g]), .out_pc(out_pc[g]),
      .out_level(lvl)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt[g]), .flush_cnt(flush_cnt[g])
`endif
    );
    assign out_level[g] = 4'(lvl);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: model occupancy from the queue, compare every cycle away from the edge
  always @(negedge clk) begin
    bit          ev, er;
    int          sz;
    logic [63:0] head;
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        sb[i].delete();
        exp_stall[i] = 0;
        exp_flush[i] = 0;
      end else begin
        sz = sb[i].size();
        ev = !flush[i] && (sz != 0);
        er = !flush[i] && ((sz < depth_of(i)) || out_ready[i]);
        check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(ev));
        check($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(er));
        check($sformatf("level[%0d]", i), 64'(out_level[i]), 64'(sz));
        if (ev) begin
          head = sb[i][0];
          check($sformatf("head_inst[%0d]", i), 64'(out_inst[i]), 64'(head[63:32]));
          check($sformatf("head_pc[%0d]", i), 64'(out_pc[i]), 64'(head[31:0]));
        end else begin
          check($sformatf("bubble_inst[%0d]", i), 64'(out_inst[i]), 64'(NOP));
          check($sformatf("bubble_pc[%0d]", i), 64'(out_pc[i]), 64'd0);
        end
`ifdef PIPE_STAGE_PERF_EN
        check($sformatf("stall_cnt[%0d]", i), 64'(stall_cnt[i]), 64'(exp_stall[i]));
        check($sformatf("flush_cnt[%0d]", i), 64'(flush_cnt[i]), 64'(exp_flush[i]));
`endif
        if (flush[i]) begin
          exp_flush[i] += sz;
          sb[i].delete();
        end else begin
          if (ev && !out_ready[i]) exp_stall[i]++;
          if (ev && out_ready[i]) begin
            void'(sb[i].pop_front());
            n_out[i]++;
          end
          if (in_valid[i] && er) sb[i].push_back({in_inst[i], in_pc[i]});
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    flush     = '0;
    in_valid  = '0;
    out_ready = '0;
    in_inst   = '0;
    in_pc     = '0;
    for (int i = 0; i < N; i++) begin
      n_out[i] = 0;
      idx[i]   = 0;
    end

    // Reset held two edges while a beat is offered
    in_valid[0] = 1'b1;
    in_inst[0]  = 32'h0000_1234;
    in_pc[0]    = 32'h40;
    repeat (2) cyc();
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_out_inst", 64'(out_inst[0]), 64'(NOP));
    check("rst_out_pc", 64'(out_pc[0]), 64'd0);
    check("rst_level", 64'(out_level[0]), 64'd0);
    check("rst_in_ready", 64'(in_ready[0]), 64'd1);

    // Streaming pc 0,4,8,C with consumer always ready
    reset        = 1'b1;
    out_ready[0] = 1'b1;
    in_inst[0]   = 32'hA000_0000;
    in_pc[0]     = 32'h0;
    #1;
    check("stream_first_no_pop", 64'(out_valid[0]), 64'd0);
    for (int k = 1; k < 4; k++) begin
      cyc();
      in_inst[0] = 32'hA000_0000 + 32'(k);
      in_pc[0]   = 32'(4 * k);
      #1;
      check("stream_valid", 64'(out_valid[0]), 64'd1);
      check("stream_pc", 64'(out_pc[0]), 64'(4 * (k - 1)));
      check("stream_level", 64'(out_level[0]), 64'd1);
    end
    cyc();
    in_valid[0] = 1'b0;
    #1;
    check("stream_last_pc", 64'(out_pc[0]), 64'hC);
    cyc();
    check("stream_drained", 64'(out_valid[0]), 64'd0);

    // Backpressure: third beat must be refused at level 2
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_inst[0]   = 32'hB000_0000;
    in_pc[0]     = 32'h100;
    cyc();
    in_inst[0] = 32'hB000_0001;
    in_pc[0]   = 32'h104;
    cyc();
    in_inst[0] = 32'hB000_0002;
    in_pc[0]   = 32'h108;
    #1;
    check("bp_in_ready", 64'(in_ready[0]), 64'd0);
    check("bp_level", 64'(out_level[0]), 64'd2);
    check("bp_head_pc", 64'(out_pc[0]), 64'h100);
    cyc();
    check("bp_hold_level", 64'(out_level[0]), 64'd2);

    // Full with consumer ready: push and pop on the same edge
    out_ready[0] = 1'b1;
    #1;
    check("full_pop_in_ready", 64'(in_ready[0]), 64'd1);
    cyc();
    check("full_pop_level", 64'(out_level[0]), 64'd2);
    check("full_pop_head", 64'(out_pc[0]), 64'h104);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;

    // Flush at level 2 leaves a bubble
    flush[0] = 1'b1;
    #1;
    check("flush_out_valid", 64'(out_valid[0]), 64'd0);
    check("flush_in_ready", 64'(in_ready[0]), 64'd0);
    cyc();
    flush[0] = 1'b0;
    #1;
    check("post_flush_valid", 64'(out_valid[0]), 64'd0);
    check("post_flush_inst", 64'(out_inst[0]), 64'(NOP));
    check("post_flush_pc", 64'(out_pc[0]), 64'd0);
    check("post_flush_level", 64'(out_level[0]), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("post_flush_cnt", 64'(flush_cnt[0]), 64'd2);
`endif

    // Flush and reset on the same edge: reset wins, counters cleared
    in_valid[0] = 1'b1;
    in_inst[0]  = 32'hC000_0000;
    in_pc[0]    = 32'h200;
    cyc();
    in_valid[0] = 1'b0;
    #1;
    check("pre_rst_flush_level", 64'(out_level[0]), 64'd1);
    flush[0] = 1'b1;
    reset    = 1'b0;
    cyc();
    flush[0] = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_flush_level", 64'(out_level[0]), 64'd0);
    check("rst_flush_valid", 64'(out_valid[0]), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("rst_flush_cnt", 64'(flush_cnt[0]), 64'd0);
`endif

    // DEPTH=1 and DEPTH=3: ten beats each under random backpressure
    for (int c = 0; c < 300 && (idx[1] < 10 || idx[2] < 10); c++) begin
      for (int j = 1; j < N; j++) begin
        in_valid[j]  = (idx[j] < 10);
        in_inst[j]   = 32'hD000_0000 | (32'(j) << 8) | 32'(idx[j]);
        in_pc[j]     = 32'(idx[j] * 4);
        out_ready[j] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      for (int j = 1; j < N; j++) begin
        if (in_valid[j] && in_ready[j]) idx[j]++;
      end
      cyc();
    end
    for (int j = 1; j < N; j++) begin
      in_valid[j]  = 1'b0;
      out_ready[j] = 1'b1;
    end
    repeat (6) cyc();
    for (int j = 1; j < N; j++) begin
      check($sformatf("wrap_accepted[%0d]", j), 64'(idx[j]), 64'd10);
      check($sformatf("wrap_delivered[%0d]", j), 64'(n_out[j]), 64'd10);
      check($sformatf("wrap_empty[%0d]", j), 64'(out_level[j]), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
